parity_mem: RTL

PARITY_MEM -- requirements
Module: parity_mem

---
 rtl/parity_mem_pkg.sv | 12 +
 rtl/parity_mem_array.sv | 36 +++
 rtl/parity_mem.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/parity_mem_pkg.sv
// Shared types and constants for the parity-protected memory.
// Holds the FSM state encoding and the error counter width.
package parity_mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/parity_mem_array.sv
// Storage array: W bits wide, DEPTH words deep.
// Ports: clk, rst_n, write port (we/waddr/wdata),
// registered read port (re/raddr -> rdata, read-first).
module parity_mem_array #(
    parameter int W     = 9,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata only moves on a read so the top can hold data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/parity_mem.sv
// Parity-protected single-port memory with post-reset clear.
// Ports: clk, rst_n, write, read, address, data_in,
// [inj_err when PARITY_INJECT_EN is defined], data_out,
// rd_valid, ready, addr_err, parity_err, err_cnt.
module parity_mem
    import parity_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    data_in,
`ifdef PARITY_INJECT_EN
    input  logic                 inj_err,
`endif
    output logic [DATA_W:0]      data_out,
    output logic                 rd_valid,
    output logic                 ready,
    output logic                 addr_err,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW = DATA_W + 1;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_nxt;

    logic           inj;
    logic           in_rng;
    logic           we;
    logic           re;
    logic [PW-1:0]  waddr;
    logic [MW-1:0]  wdata;
    logic [MW-1:0]  rdata;

    logic           rd_valid_q;
    logic           addr_err_q;
    logic           oob_q;
    logic           perr_q;
    logic           mis;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [ERR_CNT_W-1:0] cnt_nxt;

`ifdef PARITY_INJECT_EN
    assign inj = inj_err;
`else
    assign inj = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            INIT: begin
                ptr_nxt = ptr + PW'(1);
                if (ptr == PW'(DEPTH - 1)) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign ready  = (state == READY);
    assign in_rng = (32'(address) < 32'(DEPTH));

    // INIT owns the write port to clear one word per cycle.
    assign we    = !ready || (write && in_rng);
    assign waddr = ready ? address[PW-1:0] : ptr;
    assign wdata = ready ? {(^data_in) ^ inj, data_in} : '0;
    assign re    = ready && read && in_rng;

    parity_mem_array #(
        .W     (MW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (address[PW-1:0]),
        .rdata (rdata)
    );

    // oob_q remembers whether the latest read was out of range,
    // so data_out stays 0 until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            oob_q      <= 1'b0;
            perr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rd_valid_q <= ready && read;
            addr_err_q <= ready && (read || write) && !in_rng;
            if (ready && read) begin
                oob_q <= !in_rng;
            end
            perr_q <= parity_err;
            cnt_q  <= cnt_nxt;
        end
    end

    // The check runs on the registered read data so the error
    // flags rise in the same cycle as rd_valid.
    assign mis = rd_valid_q && !oob_q &&
                 (rdata[DATA_W] != ^rdata[DATA_W-1:0]);

    always_comb begin
        cnt_nxt = cnt_q;
        if (mis && (cnt_q != '1)) begin
            cnt_nxt = cnt_q + ERR_CNT_W'(1);
        end
    end

    assign data_out   = oob_q ? '0 : rdata;
    assign rd_valid   = rd_valid_q;
    assign addr_err   = addr_err_q;
    assign parity_err = perr_q || mis;
    assign err_cnt    = cnt_nxt;

endmodule
